// File: rtl/raman_accum_if.sv
// Purpose : readout stream of the Raman trace accumulator (one bin per beat).
// Signals : valid/ready handshake, data = scaled bin sum, index = bin number,
//           last = high with the final bin of a frame.
// Modports: master = accumulator side, slave = downstream consumer.
interface raman_accum_if #(
    parameter int OUT_W = 14,
    parameter int PT_W  = 4
) ();
    logic             valid;
    logic             ready;
    logic [OUT_W-1:0] data;
    logic [PT_W-1:0]  index;
    logic             last;

    modport master (output valid, data, index, last, input ready);
    modport slave  (input valid, data, index, last, output ready);
endinterface

// File: rtl/raman_accum.sv
// Purpose : triggered trace accumulator. Each rising edge of i_enable captures
//           POINTS consecutive ADC samples; sample p of each measurement is summed
//           into bin p. After MEASURES measurements the bins are streamed out as
//           sum >> SHIFT over the o_out valid/ready port.
// Ports   : clk, rst_n (async, active low)
//           i_enable  trigger, counted on 0->1 only
//           i_data    ADC sample
//           i_clear   synchronous abort back to IDLE, measure count 0
//           o_out     readout stream (raman_accum_if.master)
//           o_busy    high in WAIT, CAPTURE, DUMP
//           o_frame_done  one-cycle pulse on the final readout handshake
//           o_overrun sticky, a trigger was dropped; cleared by i_clear
//           o_cnt_measure measurements completed in the current frame
//
// state   | meaning
// IDLE    | waiting for a trigger
// WAIT    | trigger seen, counting down DELAY cycles
// CAPTURE | one sample per cycle into bins 0..POINTS-1
// DUMP    | streaming scaled bins out, one per handshake
module raman_accum #(
    parameter int DATA_W   = 12,
    parameter int POINTS   = 1500,
    parameter int MEASURES = 100000,
    parameter int DELAY    = 0,
    parameter int SHIFT    = 0,
    localparam int PT_W    = $clog2(POINTS),
    localparam int MS_W    = $clog2(MEASURES + 1),
    localparam int ACC_W   = DATA_W + $clog2(MEASURES),
    localparam int OUT_W   = ACC_W - SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clear,
    raman_accum_if.master     o_out,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overrun,
    output logic [MS_W-1:0]   o_cnt_measure
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_DUMP = 2'd3;
    localparam logic [7:0]      DLY_LAST = 8'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [PT_W-1:0] PT_LAST  = PT_W'(POINTS - 1);
    localparam logic [MS_W-1:0] MS_FULL  = MS_W'(MEASURES);

    logic [1:0]        r_state;
    logic              r_en_prev;
    logic [7:0]        r_dly;
    logic [PT_W-1:0]   r_pt;
    logic [MS_W-1:0]   r_cnt;
    logic              r_ovr;
    logic              r_fd;

    // capture pipeline: stage 1 holds the sample and the old bin value
    logic              r_s1_vld;
    logic              r_s1_first;
    logic [PT_W-1:0]   r_s1_addr;
    logic [DATA_W-1:0] r_s1_data;
    logic [ACC_W-1:0]  r_s1_rd;
    logic [ACC_W-1:0]  r_mem [POINTS];

    logic              r_valid;
    logic              r_last;
    logic [OUT_W-1:0]  r_data;
    logic [PT_W-1:0]   r_index;

    logic              w_trig;
    logic              w_pt_end;
    logic              w_hs;
    logic              w_load;
    logic [PT_W-1:0]   w_ld_idx;
    logic [MS_W-1:0]   w_cnt_inc;

    assign w_trig    = i_enable & ~r_en_prev;
    assign w_pt_end  = (r_pt == PT_LAST);
    assign w_hs      = r_valid & o_out.ready;
    // output register refills when empty or when a non-final beat is accepted
    assign w_load    = (r_state == S_DUMP) & (~r_valid | (o_out.ready & ~r_last));
    assign w_ld_idx  = r_valid ? r_index + PT_W'(1) : '0;
    assign w_cnt_inc = r_cnt + MS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_en_prev  <= 1'b0;
            r_dly      <= '0;
            r_pt       <= '0;
            r_cnt      <= '0;
            r_ovr      <= 1'b0;
            r_fd       <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_index    <= '0;
        end else begin
            r_en_prev <= i_enable;
            r_fd      <= 1'b0;
            r_s1_vld  <= 1'b0;
            if (i_clear) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_cnt   <= '0;
                r_ovr   <= 1'b0;
            end else begin
                if (w_trig && (r_state != S_IDLE)) begin
                    r_ovr <= 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_trig) begin
                            r_pt <= '0;
                            if (DELAY == 0) begin
                                r_state <= S_CAPT;
                            end else begin
                                r_state <= S_WAIT;
                                r_dly   <= DLY_LAST;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (r_dly == 8'd0) begin
                            r_state <= S_CAPT;
                        end else begin
                            r_dly <= r_dly - 8'd1;
                        end
                    end
                    S_CAPT: begin
                        r_s1_vld   <= 1'b1;
                        r_s1_addr  <= r_pt;
                        r_s1_data  <= i_data;
                        r_s1_first <= (r_cnt == '0);
                        r_pt       <= r_pt + PT_W'(1);
                        if (w_pt_end) begin
                            r_cnt   <= w_cnt_inc;
                            r_state <= (w_cnt_inc == MS_FULL) ? S_DUMP : S_IDLE;
                        end
                    end
                    default: begin
                        if (w_hs && r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_cnt   <= '0;
                            r_fd    <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (w_load) begin
                            // the last bin's write-back lands the cycle after DUMP
                            // starts; it is read no earlier than POINTS-1 cycles later
                            r_valid <= 1'b1;
                            r_index <= w_ld_idx;
                            r_last  <= (w_ld_idx == PT_LAST);
                            r_data  <= r_mem[w_ld_idx][ACC_W-1:SHIFT];
                        end
                    end
                endcase
            end
        end
    end

    // bin RAM: read the old sum while sampling, write the new sum one cycle later.
    // Measure 0 overwrites, so contents never need clearing.
    always_ff @(posedge clk) begin
        if (r_state == S_CAPT) begin
            r_s1_rd <= r_mem[r_pt];
        end
        if (r_s1_vld) begin
            r_mem[r_s1_addr] <= r_s1_first ? ACC_W'(r_s1_data)
                                           : r_s1_rd + ACC_W'(r_s1_data);
        end
    end

    assign o_out.valid   = r_valid;
    assign o_out.data    = r_data;
    assign o_out.index   = r_index;
    assign o_out.last    = r_last;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_fd;
    assign o_overrun     = r_ovr;
    assign o_cnt_measure = r_cnt;
endmodule

// File: tb/tb_raman_accum.sv
module tb_raman_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic unexp(string nm);
        total++;
        bad++;
        $display("FAIL %s: got an output beat, expected none", nm);
    endtask

    // main DUT: POINTS=10 MEASURES=4 DELAY=1 SHIFT=2
    logic        en = 1'b0, clr = 1'b0;
    logic [11:0] din = '0;
    logic        busy, fdone, ovr;
    logic [2:0]  cnt;
    raman_accum_if #(.OUT_W(12), .PT_W(4)) mo ();
    raman_accum #(.DATA_W(12), .POINTS(10), .MEASURES(4), .DELAY(1), .SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(en), .i_data(din), .i_clear(clr),
        .o_out(mo), .o_busy(busy), .o_frame_done(fdone), .o_overrun(ovr),
        .o_cnt_measure(cnt));

    // secondary DUTs share en2/din2: SHIFT=0, DELAY=0, DELAY=3
    logic        en2 = 1'b0;
    logic [11:0] din2 = '0;
    logic [2:0]  sec_busy, sec_fd, sec_ovr;
    logic [2:0]  s0_cnt;
    logic        d0_cnt, d3_cnt;
    raman_accum_if #(.OUT_W(14), .PT_W(4)) so ();
    raman_accum_if #(.OUT_W(12), .PT_W(4)) d0o ();
    raman_accum_if #(.OUT_W(12), .PT_W(4)) d3o ();
    raman_accum #(.DATA_W(12), .POINTS(10), .MEASURES(4), .DELAY(1), .SHIFT(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .i_enable(en2), .i_data(din2), .i_clear(1'b0),
        .o_out(so), .o_busy(sec_busy[0]), .o_frame_done(sec_fd[0]), .o_overrun(sec_ovr[0]),
        .o_cnt_measure(s0_cnt));
    raman_accum #(.DATA_W(12), .POINTS(10), .MEASURES(1), .DELAY(0), .SHIFT(0)) dut_d0 (
        .clk(clk), .rst_n(rst_n), .i_enable(en2), .i_data(din2), .i_clear(1'b0),
        .o_out(d0o), .o_busy(sec_busy[1]), .o_frame_done(sec_fd[1]), .o_overrun(sec_ovr[1]),
        .o_cnt_measure(d0_cnt));
    raman_accum #(.DATA_W(12), .POINTS(10), .MEASURES(1), .DELAY(3), .SHIFT(0)) dut_d3 (
        .clk(clk), .rst_n(rst_n), .i_enable(en2), .i_data(din2), .i_clear(1'b0),
        .o_out(d3o), .o_busy(sec_busy[2]), .o_frame_done(sec_fd[2]), .o_overrun(sec_ovr[2]),
        .o_cnt_measure(d3_cnt));

    typedef struct {int data; int idx; bit last;} exp_t;
    exp_t q_main[$], q_s0[$], q_d0[$], q_d3[$];
    exp_t em, es;

    typedef struct {int add; bit late; int rmode; bit exp_ovr;} row_t;
    row_t rows[4];

    // ready generator: 0 = always, 1 = toggle then 5-cycle stall, 2 = random
    int rdy_mode = 0;
    initial begin
        int lm;
        int rc;
        lm = 0;
        rc = 0;
        mo.ready = 1'b1;
        so.ready = 1'b1;
        d0o.ready = 1'b1;
        d3o.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode != lm) begin
                rc = 0;
                lm = rdy_mode;
            end
            case (rdy_mode)
                1:       mo.ready = (rc < 8) ? (rc % 2 == 0) : (rc >= 13);
                2:       mo.ready = 1'($urandom_range(0, 1));
                default: mo.ready = 1'b1;
            endcase
            rc++;
        end
    end

    // main monitor: scoreboard pop on handshake, stability while stalled
    bit pst = 0;
    int pd, pi;
    bit pl;
    int fd_main = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pst = 0;
        end else begin
            if (pst) begin
                chk("stall_valid", mo.valid, 1);
                chk("stall_data", mo.data, pd);
                chk("stall_index", mo.index, pi);
                chk("stall_last", mo.last, pl);
            end
            if (mo.valid && mo.ready) begin
                if (q_main.size() == 0) unexp("main_beat");
                else begin
                    em = q_main.pop_front();
                    chk("main_data", mo.data, em.data);
                    chk("main_index", mo.index, em.idx);
                    chk("main_last", mo.last, em.last);
                end
            end
            if (fdone) fd_main++;
            pst = mo.valid && !mo.ready;
            pd = mo.data;
            pi = mo.index;
            pl = mo.last;
        end
    end

    int fd_d0 = 0, fd_d3 = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (so.valid && so.ready) begin
                if (q_s0.size() == 0) unexp("s0_beat");
                else begin
                    es = q_s0.pop_front();
                    chk("s0_data", so.data, es.data);
                    chk("s0_index", so.index, es.idx);
                end
            end
            if (d0o.valid && d0o.ready) begin
                if (q_d0.size() == 0) unexp("d0_beat");
                else begin
                    es = q_d0.pop_front();
                    chk("d0_data", d0o.data, es.data);
                    chk("d0_index", d0o.index, es.idx);
                end
            end
            if (d3o.valid && d3o.ready) begin
                if (q_d3.size() == 0) unexp("d3_beat");
                else begin
                    es = q_d3.pop_front();
                    chk("d3_data", d3o.data, es.data);
                    chk("d3_index", d3o.index, es.idx);
                end
            end
            if (sec_fd[1]) fd_d0++;
            if (sec_fd[2]) fd_d3++;
        end
    end

    // one measurement on the main DUT: bin j gets j+k+add
    task automatic measure(int k, int add, bit late);
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            din = 12'(j + k + add);
            if (late && j == 3) en = 1'b1;
            if (late && j == 4) en = 1'b0;
            @(negedge clk);
        end
        din = 12'hFFF;
    endtask

    task automatic run_frame(row_t r);
        int fd0;
        bit seen;
        for (int j = 0; j < 10; j++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < 4; k++) sum += j + k + r.add;
            q_main.push_back('{sum >> 2, j, (j == 9)});
        end
        fd0 = fd_main;
        for (int k = 0; k < 4; k++) begin
            measure(k, r.add, r.late);
            if (k < 3) begin
                chk("cnt_measure", cnt, k + 1);
                repeat (50) @(negedge clk);
            end
        end
        rdy_mode = r.rmode;
        chk("busy_in_dump", busy, 1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (mo.valid) seen = 1;
            if (i < 3) @(negedge clk);
        end
        chk("first_valid_latency", seen, 1);
        for (int i = 0; i < 300 && fd_main == fd0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("frame_done_once", fd_main - fd0, 1);
        chk("queue_empty", q_main.size(), 0);
        q_main.delete();
        chk("cnt_after_dump", cnt, 0);
        chk("busy_after_dump", busy, 0);
        chk("overrun", ovr, r.exp_ovr);
        rdy_mode = 0;
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        chk("overrun_cleared", ovr, 0);
    endtask

    initial begin
        int f0, f3;
        rows[0] = '{add: 0, late: 1'b0, rmode: 0, exp_ovr: 1'b0};
        rows[1] = '{add: 0, late: 1'b1, rmode: 0, exp_ovr: 1'b1};
        rows[2] = '{add: 5, late: 1'b0, rmode: 1, exp_ovr: 1'b0};
        rows[3] = '{add: 9, late: 1'b0, rmode: 2, exp_ovr: 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", mo.valid, 0);
        chk("rst_last", mo.last, 0);
        chk("rst_data", mo.data, 0);
        chk("rst_index", mo.index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", fdone, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_cnt", cnt, 0);

        for (int r = 0; r < 4; r++) run_frame(rows[r]);

        // clear after two measurements, with a same-cycle trigger
        measure(0, 50, 0);
        repeat (20) @(negedge clk);
        measure(1, 50, 0);
        repeat (5) @(negedge clk);
        chk("cnt_before_clear", cnt, 2);
        clr = 1'b1;
        en = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("clear_cnt", cnt, 0);
        chk("clear_busy", busy, 0);
        chk("clear_trig_no_overrun", ovr, 0);
        run_frame(rows[0]);

        // reset mid-CAPTURE of the second measurement
        measure(0, 70, 0);
        repeat (10) @(negedge clk);
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", mo.valid, 0);
        chk("midrst_cnt", cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        run_frame(rows[0]);

        // SHIFT=0 full-scale accumulation, DELAY variants see each trigger
        for (int j = 0; j < 10; j++) q_s0.push_back('{16380, j, (j == 9)});
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 10; j++) begin
                q_d0.push_back('{4095, j, (j == 9)});
                q_d3.push_back('{4095, j, (j == 9)});
            end
            @(negedge clk);
            en2 = 1'b1;
            din2 = 12'hFFF;
            @(negedge clk) en2 = 1'b0;
            repeat (50) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        chk("s0_queue_empty", q_s0.size(), 0);
        chk("d0_queue_empty_a", q_d0.size(), 0);
        chk("d3_queue_empty_a", q_d3.size(), 0);
        q_d0.delete();
        q_d3.delete();

        // capture alignment: data = cycles since trigger edge; enable held 20 cycles
        for (int p = 0; p < 10; p++) begin
            q_d0.push_back('{p + 1, p, (p == 9)});
            q_d3.push_back('{p + 4, p, (p == 9)});
        end
        f0 = fd_d0;
        f3 = fd_d3;
        @(negedge clk);
        en2 = 1'b1;
        din2 = '0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            din2 = 12'(t);
            if (t == 20) en2 = 1'b0;
        end
        repeat (40) @(negedge clk);
        chk("d0_frames", fd_d0 - f0, 1);
        chk("d3_frames", fd_d3 - f3, 1);
        chk("d0_queue_empty_b", q_d0.size(), 0);
        chk("d3_queue_empty_b", q_d3.size(), 0);
        chk("d0_held_no_overrun", sec_ovr[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
